ac_motor_vf_ramp_ctrl: RTL and testbench

Start/stop and V/f ramp scheduler for the space-vector drive chain. It owns the `frequency` and `u_str` inputs of the sine/sector generator and the vector-time stage. It ramps them toward an operator target at a fixed rate, keeps the voltage amplitude on a V/f line with low-speed boost, and gates the bridge through `drive_en`. Fault handling is immediate; normal stops ramp down to zero before the bridge is released.

---
 rtl/ac_motor_vf_ramp_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ac_motor_vf_ramp_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_motor_vf_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// ac_motor_vf_ramp_ctrl : start/stop sequencer and V/f frequency ramp for SVM drive
// Rev 1.0
// ============================================================================
module ac_motor_vf_ramp_ctrl #(
  parameter int RAMP_DIV   = 1000,
  parameter int FREQ_STEP  = 1,
  parameter int HOLD_TICKS = 4,
  parameter int U_BOOST    = 256,
  parameter int VF_NUM     = 1,
  parameter int VF_SHIFT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        fault,
  input  logic [11:0] f_target,
  output logic [11:0] frequency,
  output logic [11:0] u_str,
  output logic        drive_en,
  output logic        at_speed,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [15:0] c_div_last  = 16'(RAMP_DIV - 1);
  localparam logic [11:0] c_step      = 12'(FREQ_STEP);
  localparam logic [7:0]  c_hold_last = 8'(HOLD_TICKS - 1);
  localparam logic [11:0] c_boost     = 12'(U_BOOST);
  localparam logic [7:0]  c_vf_num    = 8'(VF_NUM);

  state_e      state_q, state_d;
  logic [11:0] freq_q, freq_d;
  logic [11:0] ustr_q, ustr_d;
  logic        en_q, en_d;
  logic        at_speed_q, at_speed_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        w_active;
  logic        w_tick;
  logic [11:0] w_ramp;

  // Saturate before truncation so large products clamp instead of wrapping.
  function automatic logic [11:0] vf_law(input logic [11:0] f);
    logic [19:0] prod;
    logic [20:0] sum;
    prod = {8'd0, f} * {12'd0, c_vf_num};
    sum  = {1'b0, prod >> VF_SHIFT} + {9'd0, c_boost};
    return (sum > 21'd4095) ? 12'hFFF : sum[11:0];
  endfunction

  function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt);
    if (tgt >= cur) begin
      return ((tgt - cur) <= c_step) ? tgt : cur + c_step;
    end
    return ((cur - tgt) <= c_step) ? tgt : cur - c_step;
  endfunction

  assign w_active = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_STOP);
  assign w_tick   = w_active && (cnt_q == c_div_last);
  assign w_ramp   = step_toward(freq_q, f_target);

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    ustr_d  = ustr_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (w_active) begin
      cnt_d = w_tick ? 16'd0 : 16'(cnt_q + 16'd1);
    end

    case (state_q)
      ST_IDLE: begin
        freq_d = 12'd0;
        ustr_d = 12'd0;
        en_d   = 1'b0;
        cnt_d  = 16'd0;
        hold_d = 8'd0;
        if (start && !stop) begin
          state_d = ST_START;
          en_d    = 1'b1;
          ustr_d  = c_boost;
        end
      end
      ST_START: begin
        if (stop) begin
          state_d = ST_STOP;
        end else if (w_tick) begin
          hold_d = 8'(hold_q + 8'd1);
          if (hold_q == c_hold_last) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop || !start) begin
          state_d = ST_STOP;
        end else if (w_tick) begin
          freq_d = w_ramp;
          ustr_d = vf_law(w_ramp);
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (freq_q <= c_step) begin
            state_d = ST_IDLE;
            freq_d  = 12'd0;
            ustr_d  = 12'd0;
            en_d    = 1'b0;
          end else begin
            freq_d = freq_q - c_step;
            ustr_d = vf_law(freq_q - c_step);
          end
        end
      end
      ST_FAULT: begin
        freq_d = 12'd0;
        ustr_d = 12'd0;
        en_d   = 1'b0;
        cnt_d  = 16'd0;
        hold_d = 8'd0;
        if (!fault && !start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        freq_d  = 12'd0;
        ustr_d  = 12'd0;
        en_d    = 1'b0;
        cnt_d   = 16'd0;
        hold_d  = 8'd0;
      end
    endcase

    // Fault overrides every state on the very next edge, mid-tick included.
    if (fault) begin
      state_d = ST_FAULT;
      freq_d  = 12'd0;
      ustr_d  = 12'd0;
      en_d    = 1'b0;
      cnt_d   = 16'd0;
      hold_d  = 8'd0;
    end

    at_speed_d = (state_d == ST_RUN) && (freq_d == f_target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      freq_q     <= 12'd0;
      ustr_q     <= 12'd0;
      en_q       <= 1'b0;
      at_speed_q <= 1'b0;
      cnt_q      <= 16'd0;
      hold_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      ustr_q     <= ustr_d;
      en_q       <= en_d;
      at_speed_q <= at_speed_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign frequency = freq_q;
  assign u_str     = ustr_q;
  assign drive_en  = en_q;
  assign at_speed  = at_speed_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ac_motor_vf_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ac_motor_vf_ramp_ctrl : scoreboard bench with behavioural V/f ramp model
// Rev 1.0
// ============================================================================
module tb_ac_motor_vf_ramp_ctrl;
  localparam int RAMP_DIV   = 4;
  localparam int FREQ_STEP  = 16;
  localparam int HOLD_TICKS = 2;
  localparam int U_BOOST    = 256;
  localparam int VF_NUM     = 1;
  localparam int VF_SHIFT   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        fault = 1'b0;
  logic [11:0] f_target = 12'd0;
  logic [11:0] frequency;
  logic [11:0] u_str;
  logic        drive_en;
  logic        at_speed;
  logic [2:0]  state;

  ac_motor_vf_ramp_ctrl #(
    .RAMP_DIV(RAMP_DIV), .FREQ_STEP(FREQ_STEP), .HOLD_TICKS(HOLD_TICKS),
    .U_BOOST(U_BOOST), .VF_NUM(VF_NUM), .VF_SHIFT(VF_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fault(fault),
    .f_target(f_target), .frequency(frequency), .u_str(u_str),
    .drive_en(drive_en), .at_speed(at_speed), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f;
    int u;
    int en;
    int spd;
    int st;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode number, frequency, voltage, enable, ticks since entry.
  int m_st = 0, m_f = 0, m_u = 0, m_en = 0, m_spd = 0, m_cyc = 0, m_hold = 0;
  bit m_tick = 1'b0;

  function automatic int vf(input int f);
    int v;
    v = U_BOOST + ((f * VF_NUM) >> VF_SHIFT);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_f = 0; m_u = 0; m_en = 0; m_spd = 0; m_cyc = 0; m_hold = 0; m_tick = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit fl, input int tgt);
    bit active;
    int d;
    active = (m_st >= 1) && (m_st <= 3);
    m_tick = active && ((m_cyc % RAMP_DIV) == RAMP_DIV - 1);
    if (active) m_cyc++;
    if (fl) begin
      m_st = 4; m_f = 0; m_u = 0; m_en = 0;
    end else begin
      case (m_st)
        0: if (st && !sp) begin
             m_st = 1; m_en = 1; m_u = U_BOOST; m_hold = 0; m_cyc = 0;
           end
        1: if (sp) m_st = 3;
           else if (m_tick) begin
             m_hold++;
             if (m_hold == HOLD_TICKS) m_st = 2;
           end
        2: if (sp || !st) m_st = 3;
           else if (m_tick) begin
             d = tgt - m_f;
             if (d > FREQ_STEP) m_f += FREQ_STEP;
             else if (d < -FREQ_STEP) m_f -= FREQ_STEP;
             else m_f = tgt;
             m_u = vf(m_f);
           end
        3: if (m_tick) begin
             m_f = (m_f > FREQ_STEP) ? m_f - FREQ_STEP : 0;
             if (m_f == 0) begin
               m_st = 0; m_en = 0; m_u = 0;
             end else begin
               m_u = vf(m_f);
             end
           end
        default: if (!st) m_st = 0;
      endcase
    end
    if (m_st == 0 || m_st == 4) m_cyc = 0;
    m_spd = (m_st == 2 && m_f == tgt) ? 1 : 0;
  endtask

  task automatic cycle(input bit st, input bit sp, input bit fl, input int tgt);
    @(negedge clk);
    start = st; stop = sp; fault = fl; f_target = 12'(tgt);
    model_step(st, sp, fl, tgt);
    sb_q.push_back('{m_f, m_u, m_en, m_spd, m_st});
    @(posedge clk);
    #1;
  endtask

  task automatic step_tick(input bit st, input bit sp, input bit fl, input int tgt);
    for (int i = 0; i < RAMP_DIV + 2; i++) begin
      cycle(st, sp, fl, tgt);
      if (m_tick) return;
    end
    checks++;
    errors++;
    $display("FAIL tick_wait: no ramp tick within %0d cycles", RAMP_DIV + 2);
  endtask

  // Monitor: every edge produces one expected output set.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_frequency", int'(frequency), e.f);
      chk("sb_u_str", int'(u_str), e.u);
      chk("sb_drive_en", int'(drive_en), e.en);
      chk("sb_at_speed", int'(at_speed), e.spd);
      chk("sb_state", int'(state), e.st);
    end
  end

  initial begin
    bit st, sp, fl;
    int tgt;
    #3;
    chk("rst_frequency", int'(frequency), 0);
    chk("rst_u_str", int'(u_str), 0);
    chk("rst_drive_en", int'(drive_en), 0);
    chk("rst_at_speed", int'(at_speed), 0);
    chk("rst_state", int'(state), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Start toward 64
    cycle(1, 0, 0, 64);
    chk("start_drive_en", int'(drive_en), 1);
    chk("start_u_boost", int'(u_str), 256);
    chk("start_state", int'(state), 1);
    repeat (7) cycle(1, 0, 0, 64);
    chk("hold_still_start", int'(state), 1);
    cycle(1, 0, 0, 64);
    chk("run_after_8", int'(state), 2);
    chk("run_entry_freq", int'(frequency), 0);
    for (int k = 1; k <= 4; k++) begin
      step_tick(1, 0, 0, 64);
      chk("ramp_up_freq", int'(frequency), 16 * k);
      chk("ramp_up_u", int'(u_str), 256 + 16 * k);
    end
    chk("at_speed_64", int'(at_speed), 1);

    // Ramp-down stop from 64
    for (int k = 3; k >= 1; k--) begin
      step_tick(1, 1, 0, 64);
      chk("stop_freq", int'(frequency), 16 * k);
    end
    step_tick(1, 1, 0, 64);
    chk("stop_zero_freq", int'(frequency), 0);
    chk("stop_zero_state", int'(state), 0);
    chk("stop_zero_en", int'(drive_en), 0);
    chk("stop_zero_u", int'(u_str), 0);
    cycle(1, 1, 0, 64);
    chk("start_stop_idle", int'(state), 0);

    // Target 40: no overshoot
    cycle(1, 0, 0, 40);
    step_tick(1, 0, 0, 40);
    chk("t40_hold", int'(state), 1);
    step_tick(1, 0, 0, 40);
    chk("t40_run", int'(state), 2);
    step_tick(1, 0, 0, 40);
    chk("t40_16", int'(frequency), 16);
    step_tick(1, 0, 0, 40);
    chk("t40_32", int'(frequency), 32);
    step_tick(1, 0, 0, 40);
    chk("t40_40", int'(frequency), 40);
    chk("t40_at_speed", int'(at_speed), 1);
    cycle(0, 0, 0, 40);
    chk("start_drop_stop", int'(state), 3);
    for (int i = 0; i < 10 && m_st != 0; i++) step_tick(0, 0, 0, 40);
    chk("t40_back_idle", int'(state), 0);

    // Fault mid-ramp at 32
    cycle(1, 0, 0, 64);
    repeat (4) step_tick(1, 0, 0, 64);
    chk("pre_fault_freq", int'(frequency), 32);
    cycle(1, 0, 0, 64);
    cycle(1, 0, 1, 64);
    chk("fault_freq", int'(frequency), 0);
    chk("fault_u", int'(u_str), 0);
    chk("fault_en", int'(drive_en), 0);
    chk("fault_state", int'(state), 4);
    repeat (3) cycle(1, 0, 0, 64);
    chk("fault_hold_start", int'(state), 4);
    cycle(0, 0, 0, 64);
    chk("fault_release", int'(state), 0);

    // Saturation toward 4095
    cycle(1, 0, 0, 4095);
    repeat (2) step_tick(1, 0, 0, 4095);
    for (int i = 0; i < 300 && m_f != 4095; i++) begin
      step_tick(1, 0, 0, 4095);
      if (m_f == 3824) chk("u_below_sat", int'(u_str), 4080);
      if (m_f == 3840) chk("u_sat", int'(u_str), 4095);
    end
    chk("fmax_freq", int'(frequency), 4095);
    chk("fmax_u", int'(u_str), 4095);
    chk("fmax_at_speed", int'(at_speed), 1);
    for (int i = 0; i < 300 && m_st != 0; i++) step_tick(1, 1, 0, 4095);
    chk("fmax_stop_idle", int'(state), 0);

    // Asynchronous reset mid-START
    cycle(1, 0, 0, 100);
    cycle(1, 0, 0, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_freq", int'(frequency), 0);
    chk("arst_u", int'(u_str), 0);
    chk("arst_en", int'(drive_en), 0);
    chk("arst_state", int'(state), 0);
    start = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 100);
    chk("arst_restart_state", int'(state), 1);
    chk("arst_restart_en", int'(drive_en), 1);

    // Randomized segments
    tgt = 100;
    for (int seg = 0; seg < 120; seg++) begin
      st = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) tgt = $urandom_range(0, 4095);
      else tgt = $urandom_range(0, 200);
      for (int c = 0; c < int'($urandom_range(4, 60)); c++) begin
        sp = ($urandom_range(0, 59) == 0);
        fl = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 79) == 0) tgt = $urandom_range(0, 4095);
        cycle(st, sp, fl, tgt);
      end
    end

    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
